// File: rtl/avalon_to_wb_bridge.sv
// rtl/avalon_to_wb_bridge.sv - Avalon-MM slave to Wishbone B4 master bridge
// Avalon bursts become incrementing Wishbone bursts with one beat outstanding.
module avalon_to_wb_bridge #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int BCW = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [AW-1:0]   s_av_address_i,
  input  logic [DW/8-1:0] s_av_byteenable_i,
  input  logic            s_av_read_i,
  input  logic            s_av_write_i,
  input  logic [DW-1:0]   s_av_writedata_i,
  input  logic [BCW-1:0]  s_av_burstcount_i,
  output logic [DW-1:0]   s_av_readdata_o,
  output logic            s_av_readdatavalid_o,
  output logic            s_av_waitrequest_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  output logic            bus_err_o
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   adr_q;
  logic [BCW-1:0]  cnt_q;
  logic [BCW-1:0]  burst_len;
  logic [SW-1:0]   sel_q;
  logic            single_q;
  logic            rdv_q;
  logic [DW-1:0]   rdata_q;
  logic            berr_q;
  logic            start_wr, start_rd, beat_done, last_beat;

  assign start_wr  = (state == IDLE) && s_av_write_i;
  assign start_rd  = (state == IDLE) && s_av_read_i && !s_av_write_i;
  assign beat_done = wb_stb_o && (wb_ack_i || wb_err_i);
  assign last_beat = (cnt_q == BCW'(1));
  assign burst_len = (s_av_burstcount_i == '0) ? BCW'(1) : s_av_burstcount_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_wr) state_nxt = WRITE;
               else if (start_rd) state_nxt = READ;
      READ,
      WRITE:   if (beat_done && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb_cyc_o           = 1'b0;
    wb_stb_o           = 1'b0;
    wb_we_o            = 1'b0;
    wb_sel_o           = sel_q;
    s_av_waitrequest_o = 1'b1;
    case (state)
      IDLE:  s_av_waitrequest_o = !start_rd;
      READ: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
      end
      WRITE: begin
        wb_cyc_o           = 1'b1;
        wb_stb_o           = s_av_write_i;
        wb_we_o            = 1'b1;
        wb_sel_o           = s_av_byteenable_i;
        s_av_waitrequest_o = !(s_av_write_i && (wb_ack_i || wb_err_i));
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      adr_q    <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      single_q <= 1'b0;
      rdv_q    <= 1'b0;
      rdata_q  <= '0;
      berr_q   <= 1'b0;
    end else begin
      rdv_q  <= (state == READ) && beat_done;
      berr_q <= beat_done && wb_err_i;
      if ((state == READ) && beat_done) rdata_q <= wb_dat_i;
      if (start_wr || start_rd) begin
        adr_q    <= s_av_address_i;
        cnt_q    <= burst_len;
        single_q <= (burst_len == BCW'(1));
      end else if (beat_done) begin
        adr_q <= adr_q + AW'(SW);
        cnt_q <= cnt_q - BCW'(1);
      end
      if (start_rd) sel_q <= s_av_byteenable_i;
    end
  end

  // Classic cycle for single beats; the final beat of a burst signals end-of-burst.
  assign wb_cti_o = ((state != IDLE) && !single_q) ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
  assign wb_bte_o = 2'b00;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = s_av_writedata_i;

  assign s_av_readdata_o      = rdata_q;
  assign s_av_readdatavalid_o = rdv_q;
  assign bus_err_o            = berr_q;

endmodule

// File: tb/tb_avalon_to_wb_bridge.sv
// tb/tb_avalon_to_wb_bridge.sv - directed bench for avalon_to_wb_bridge
// Read beats are scoreboarded: expectation pushed at ack, popped on the following cycle.
module tb_avalon_to_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0;
  logic [3:0]  byteenable = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [7:0]  burstcount = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_out;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] wb_dat_in = '0;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  avalon_to_wb_bridge #(.DW(32), .AW(32), .BCW(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .s_av_address_i(address), .s_av_byteenable_i(byteenable),
    .s_av_read_i(read), .s_av_write_i(write),
    .s_av_writedata_i(writedata), .s_av_burstcount_i(burstcount),
    .s_av_readdata_o(readdata), .s_av_readdatavalid_o(readdatavalid),
    .s_av_waitrequest_o(waitrequest),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_out), .wb_sel_o(wb_sel),
    .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
    .wb_dat_i(wb_dat_in), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [32:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rdv", {63'd0, readdatavalid}, 64'd1);
      chk("rdata", {32'd0, readdata}, {32'd0, e[31:0]});
      chk("rd_bus_err", {63'd0, bus_err}, {63'd0, e[32]});
    end else begin
      chk("rdv_quiet", {63'd0, readdatavalid}, 64'd0);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic start_read(input logic [31:0] a, input logic [7:0] bc);
    address = a; burstcount = bc; byteenable = 4'hF; read = 1'b1;
    settle();
    chk("rd_accept_wait", {63'd0, waitrequest}, 64'd0);
    tick();
    read = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_cyc", {63'd0, wb_cyc}, 64'd0);
    chk("rst_stb", {63'd0, wb_stb}, 64'd0);
    chk("rst_rdv", {63'd0, readdatavalid}, 64'd0);
    chk("rst_rdata", {32'd0, readdata}, 64'd0);
    chk("rst_berr", {63'd0, bus_err}, 64'd0);
    chk("rst_wait", {63'd0, waitrequest}, 64'd1);
    chk("rst_adr", {32'd0, wb_adr}, 64'd0);
    chk("bte", {62'd0, wb_bte}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single write, ack two cycles after stb
    address = 32'h100; writedata = 32'hCAFEF00D; byteenable = 4'hF; burstcount = 8'd1; write = 1'b1;
    settle();
    chk("wr1_idle_wait", {63'd0, waitrequest}, 64'd1);
    tick();
    chk("wr1_cyc", {63'd0, wb_cyc}, 64'd1);
    chk("wr1_stb", {63'd0, wb_stb}, 64'd1);
    chk("wr1_we", {63'd0, wb_we}, 64'd1);
    chk("wr1_cti", {61'd0, wb_cti}, 64'd0);
    chk("wr1_adr", {32'd0, wb_adr}, 64'h100);
    chk("wr1_dat", {32'd0, wb_dat_out}, 64'hCAFEF00D);
    chk("wr1_sel", {60'd0, wb_sel}, 64'hF);
    chk("wr1_wait0", {63'd0, waitrequest}, 64'd1);
    tick();
    chk("wr1_wait1", {63'd0, waitrequest}, 64'd1);
    tick();
    wb_ack = 1'b1;
    settle();
    chk("wr1_wait_ack", {63'd0, waitrequest}, 64'd0);
    tick();
    wb_ack = 1'b0; write = 1'b0;
    settle();
    chk("wr1_cyc_end", {63'd0, wb_cyc}, 64'd0);
    chk("wr1_berr", {63'd0, bus_err}, 64'd0);

    // single read, ack after three cycles
    start_read(32'h40, 8'd1);
    chk("rd1_cyc", {63'd0, wb_cyc}, 64'd1);
    chk("rd1_we", {63'd0, wb_we}, 64'd0);
    chk("rd1_adr", {32'd0, wb_adr}, 64'h40);
    chk("rd1_cti", {61'd0, wb_cti}, 64'd0);
    chk("rd1_wait", {63'd0, waitrequest}, 64'd1);
    tick(); tick(); tick();
    wb_ack = 1'b1; wb_dat_in = 32'h12345678;
    exp_q.push_back({1'b0, 32'h12345678});
    tick();
    wb_ack = 1'b0;
    settle();
    chk("rd1_cyc_end", {63'd0, wb_cyc}, 64'd0);

    // 4-beat read burst, zero-wait slave
    start_read(32'h200, 8'd4);
    wb_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_dat_in = 32'hA000_0000 + 32'(i);
      settle();
      chk("rb_adr", {32'd0, wb_adr}, 64'h200 + 64'(4 * i));
      chk("rb_cti", {61'd0, wb_cti}, (i < 3) ? 64'd2 : 64'd7);
      chk("rb_stb", {63'd0, wb_stb}, 64'd1);
      exp_q.push_back({1'b0, wb_dat_in});
      tick();
    end
    wb_ack = 1'b0;
    settle();
    chk("rb_cyc_end", {63'd0, wb_cyc}, 64'd0);

    // 3-beat write burst with a two-cycle gap after the first beat
    address = 32'h0; burstcount = 8'd3; byteenable = 4'h3; writedata = 32'hD0; write = 1'b1;
    tick();
    wb_ack = 1'b1;
    settle();
    chk("wb0_adr", {32'd0, wb_adr}, 64'h0);
    chk("wb0_cti", {61'd0, wb_cti}, 64'd2);
    chk("wb0_sel", {60'd0, wb_sel}, 64'h3);
    chk("wb0_wait", {63'd0, waitrequest}, 64'd0);
    tick();
    write = 1'b0; wb_ack = 1'b0;
    for (int g = 0; g < 2; g++) begin
      settle();
      chk("wb_gap_stb", {63'd0, wb_stb}, 64'd0);
      chk("wb_gap_cyc", {63'd0, wb_cyc}, 64'd1);
      tick();
    end
    write = 1'b1; writedata = 32'hD1; wb_ack = 1'b1;
    settle();
    chk("wb1_adr", {32'd0, wb_adr}, 64'h4);
    chk("wb1_cti", {61'd0, wb_cti}, 64'd2);
    chk("wb1_dat", {32'd0, wb_dat_out}, 64'hD1);
    tick();
    writedata = 32'hD2;
    settle();
    chk("wb2_adr", {32'd0, wb_adr}, 64'h8);
    chk("wb2_cti", {61'd0, wb_cti}, 64'd7);
    tick();
    write = 1'b0; wb_ack = 1'b0;
    settle();
    chk("wb_cyc_end", {63'd0, wb_cyc}, 64'd0);

    // error on second beat of a 2-beat read
    start_read(32'h300, 8'd2);
    wb_ack = 1'b1; wb_dat_in = 32'h1111_2222;
    exp_q.push_back({1'b0, 32'h1111_2222});
    tick();
    wb_ack = 1'b0; wb_err = 1'b1; wb_dat_in = 32'hDEAD_BEEF;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    tick();
    wb_err = 1'b0;
    settle();
    chk("err_cyc_end", {63'd0, wb_cyc}, 64'd0);
    tick();
    chk("err_berr_clear", {63'd0, bus_err}, 64'd0);

    // reset asserted in the middle of an 8-beat read
    start_read(32'h400, 8'd8);
    wb_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_dat_in = 32'hB000_0000 + 32'(i);
      exp_q.push_back({1'b0, wb_dat_in});
      tick();
    end
    wb_ack = 1'b0;
    rst_n = 1'b0;
    settle();
    chk("rst_mid_cyc", {63'd0, wb_cyc}, 64'd0);
    chk("rst_mid_stb", {63'd0, wb_stb}, 64'd0);
    chk("rst_mid_rdv", {63'd0, readdatavalid}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    start_read(32'h44, 8'd0);
    chk("post_adr", {32'd0, wb_adr}, 64'h44);
    chk("post_cti", {61'd0, wb_cti}, 64'd0);
    wb_ack = 1'b1; wb_dat_in = 32'h5A5A_0001;
    exp_q.push_back({1'b0, 32'h5A5A_0001});
    tick();
    wb_ack = 1'b0;
    tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
